jam_cost_server: RTL and testbench

// Responder side of the JAM worker/job cost interface. Holds the 8x8 cost table
// (loaded serially after reset) and returns Cost for the W/J index pair driven by
// the solver. It also monitors the index stream, counting complete permutations
// and flagging illegal ones, and captures MinCost/MatchCount when Valid arrives.
// The solver is held in RST until ready=1.

---
 rtl/jam_cost_server.sv | 183 ++++++++++++++++++
 tb/tb_jam_cost_server.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jam_cost_server.sv
`default_nettype none
// ============================================================================
//  Module   : jam_cost_server
//  Purpose  : Responder for the JAM worker/job cost interface. Holds a serially
//             loaded 8x8 cost table, serves Cost[{W,J}] combinationally, counts
//             complete legal index permutations, flags repeated jobs within a
//             permutation and captures the solver result on Valid.
//  Revision : 1.0  initial release
// ============================================================================
module jam_cost_server #(
    parameter int COST_W = 7,
    parameter int PERM_W = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              load_en,
    input  logic [COST_W-1:0] load_data,
    output logic              ready,
    input  logic [2:0]        W,
    input  logic [2:0]        J,
    output logic [COST_W-1:0] Cost,
    input  logic [3:0]        MatchCount,
    input  logic [9:0]        MinCost,
    input  logic              Valid,
    output logic [PERM_W-1:0] perm_count,
    output logic              dup_err,
    output logic [9:0]        res_min_cost,
    output logic [3:0]        res_match_count,
    output logic              done
);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_SERVE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [5:0]          r_load_cnt;
    logic [COST_W-1:0]   r_table [0:63];
    logic                r_ready;

    logic [2:0]          r_prev_w;
    logic [7:0]          r_mask;
    logic                r_in_seq;
    logic [PERM_W-1:0]   r_perm_count;
    logic                r_dup_err;

    logic [9:0]          r_res_min_cost;
    logic [3:0]          r_res_match_count;
    logic                r_done;

    logic                w_load_wr;
    logic                w_last_load;
    logic                w_serving;
    logic                w_capture;
    logic [2:0]          w_expect_w;
    logic [7:0]          w_j_bit;

    assign w_load_wr   = (r_state == S_LOAD) && load_en;
    assign w_last_load = w_load_wr && (r_load_cnt == 6'd63);
    assign w_serving   = (r_state == S_SERVE);
    assign w_capture   = w_serving && Valid;
    assign w_expect_w  = r_prev_w + 3'd1;
    assign w_j_bit     = 8'd1 << J;

    // FSM state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and the combinational Cost lookup
    always_comb begin
        w_state_nxt = r_state;
        Cost        = '0;
        case (r_state)
            S_LOAD: begin
                if (w_last_load) begin
                    w_state_nxt = S_SERVE;
                end
            end
            S_SERVE: begin
                Cost = r_table[{W, J}];
                if (Valid) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                Cost = r_table[{W, J}];
            end
            default: begin
                w_state_nxt = S_LOAD;
            end
        endcase
    end

    // Load word counter; wraps to 0 after the 64th word
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_load_cnt <= '0;
        end else if (w_load_wr) begin
            r_load_cnt <= r_load_cnt + 6'd1;
        end
    end

    // Cost table storage; contents are only meaningful once loaded
    always_ff @(posedge CLK) begin
        if (w_load_wr) begin
            r_table[r_load_cnt] <= load_data;
        end
    end

    // ready rises on the edge that writes the last table word and then holds
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ready <= 1'b0;
        end else if (w_last_load) begin
            r_ready <= 1'b1;
        end
    end

    // Permutation tracker: follows W=0..7 runs, counting or flagging repeats
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_prev_w     <= '0;
            r_mask       <= '0;
            r_in_seq     <= 1'b0;
            r_perm_count <= '0;
            r_dup_err    <= 1'b0;
        end else if (w_serving) begin
            if (W == 3'd0) begin
                r_mask   <= w_j_bit;
                r_prev_w <= 3'd0;
                r_in_seq <= 1'b1;
            end else if (r_in_seq && (W == w_expect_w)) begin
                if ((r_mask & w_j_bit) != 8'd0) begin
                    r_dup_err <= 1'b1;
                    r_in_seq  <= 1'b0;
                end else begin
                    r_mask   <= r_mask | w_j_bit;
                    r_prev_w <= W;
                    if (W == 3'd7) begin
                        r_in_seq <= 1'b0;
                        if (r_perm_count != {PERM_W{1'b1}}) begin
                            r_perm_count <= r_perm_count + PERM_W'(1);
                        end
                    end
                end
            end else begin
                // Broken ordering: drop the partial sequence without an error
                r_in_seq <= 1'b0;
            end
        end
    end

    // Solver result capture; only the first Valid while serving is kept
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_res_min_cost    <= '0;
            r_res_match_count <= '0;
            r_done            <= 1'b0;
        end else if (w_capture) begin
            r_res_min_cost    <= MinCost;
            r_res_match_count <= MatchCount;
            r_done            <= 1'b1;
        end
    end

    assign ready           = r_ready;
    assign perm_count      = r_perm_count;
    assign dup_err         = r_dup_err;
    assign res_min_cost    = r_res_min_cost;
    assign res_match_count = r_res_match_count;
    assign done            = r_done;

endmodule
`default_nettype wire

// File: tb/tb_jam_cost_server.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jam_cost_server
//  Purpose  : Self-checking bench for jam_cost_server: table-driven tracker
//             vectors, hand-written multi-cycle sequences and randomized
//             bursts compared against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_jam_cost_server;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        load_en = 1'b0;
    logic [6:0]  load_data = '0;
    logic        ready;
    logic [2:0]  W = '0;
    logic [2:0]  J = '0;
    logic [6:0]  Cost;
    logic [3:0]  MatchCount = '0;
    logic [9:0]  MinCost = '0;
    logic        Valid = 1'b0;
    logic [15:0] perm_count;
    logic        dup_err;
    logic [9:0]  res_min_cost;
    logic [3:0]  res_match_count;
    logic        done;

    jam_cost_server #(.COST_W(7), .PERM_W(16)) dut (
        .CLK             (CLK),
        .RST             (RST),
        .load_en         (load_en),
        .load_data       (load_data),
        .ready           (ready),
        .W               (W),
        .J               (J),
        .Cost            (Cost),
        .MatchCount      (MatchCount),
        .MinCost         (MinCost),
        .Valid           (Valid),
        .perm_count      (perm_count),
        .dup_err         (dup_err),
        .res_min_cost    (res_min_cost),
        .res_match_count (res_match_count),
        .done            (done)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errs   = 0;
    int last_cost;

    // ---------------- behavioural model ----------------
    int m_tab [64];
    int m_cnt;
    bit m_serve;
    bit m_done;
    int m_seq [$];      // J values of the permutation currently being collected
    bit m_in;
    int m_perm;
    bit m_dup;
    int m_rmin;
    int m_rmc;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt   = 0;
        m_serve = 0;
        m_done  = 0;
        m_seq.delete();
        m_in    = 0;
        m_perm  = 0;
        m_dup   = 0;
        m_rmin  = 0;
        m_rmc   = 0;
    endtask

    function automatic bit seq_has(input int j);
        foreach (m_seq[k]) if (m_seq[k] == j) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_edge(input bit le, input int data, input int w, input int j,
                              input bit v, input int mc, input int mn);
        if (!m_serve) begin
            if (le) begin
                m_tab[m_cnt] = data & 127;
                m_cnt++;
                if (m_cnt == 64) m_serve = 1;
            end
        end else if (!m_done) begin
            if (w == 0) begin
                m_seq.delete();
                m_seq.push_back(j);
                m_in = 1;
            end else if (m_in && w == m_seq.size()) begin
                if (seq_has(j)) begin
                    m_dup = 1;
                    m_in  = 0;
                end else begin
                    m_seq.push_back(j);
                    if (m_seq.size() == 8) begin
                        if (m_perm < 65535) m_perm++;
                        m_in = 0;
                    end
                end
            end else begin
                m_in = 0;
            end
            if (v) begin
                m_rmin = mn & 1023;
                m_rmc  = mc & 15;
                m_done = 1;
            end
        end
    endtask

    // One clock: drive, check Cost before the edge, check registered outputs after
    task automatic tick(input bit le, input int data, input int w, input int j,
                        input bit v, input int mc, input int mn);
        load_en    = le;
        load_data  = 7'(data);
        W          = 3'(w);
        J          = 3'(j);
        Valid      = v;
        MatchCount = 4'(mc);
        MinCost    = 10'(mn);
        #1;
        last_cost = int'(Cost);
        chk("cost", int'(Cost), m_serve ? m_tab[w*8 + j] : 0);
        @(posedge CLK);
        model_edge(le, data, w, j, v, mc, mn);
        #1;
        chk("ready", int'(ready), int'(m_serve));
        chk("perm_count", int'(perm_count), m_perm);
        chk("dup_err", int'(dup_err), int'(m_dup));
        chk("done", int'(done), int'(m_done));
        chk("res_min_cost", int'(res_min_cost), m_rmin);
        chk("res_match_count", int'(res_match_count), m_rmc);
    endtask

    task automatic do_reset();
        RST     = 1'b1;
        load_en = 1'b0;
        Valid   = 1'b0;
        W       = 3'd3;
        J       = 3'd5;
        @(posedge CLK);
        model_reset();
        #1;
        RST = 1'b0;
        #1;
        chk("rst_ready", int'(ready), 0);
        chk("rst_perm", int'(perm_count), 0);
        chk("rst_dup", int'(dup_err), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_res_min", int'(res_min_cost), 0);
        chk("rst_res_mc", int'(res_match_count), 0);
        chk("rst_cost", int'(Cost), 0);
    endtask

    // Random 8-cycle bursts: clean permutations, restarts, skips, dups, noise
    task automatic burst();
        int p [8];
        int mode;
        int k;
        int t;
        int skip;
        for (int i = 0; i < 8; i++) p[i] = i;
        for (int i = 7; i > 0; i--) begin
            k = $urandom_range(0, i);
            t = p[i]; p[i] = p[k]; p[k] = t;
        end
        mode = $urandom_range(0, 9);
        if (mode == 9) p[$urandom_range(1, 7)] = p[$urandom_range(0, 7)];
        if (mode == 4) tick($urandom_range(0, 1), $urandom, 0, $urandom_range(0, 7), 0, 0, 0);
        skip = (mode == 5) ? $urandom_range(1, 7) : 8;
        for (int w = 0; w < 8; w++) begin
            if (w == skip) continue;
            if (mode >= 6 && mode <= 8)
                tick($urandom_range(0, 1), $urandom, $urandom_range(0, 7), $urandom_range(0, 7), 0, 0, 0);
            else
                tick($urandom_range(0, 1), $urandom, w, p[w], 0, 0, 0);
        end
    endtask

    typedef struct {
        int w;
        int j;
        int exp_cost;
        int exp_perm;
        bit exp_dup;
    } vec_t;

    function automatic vec_t mk(input int w, input int j, input int p, input bit d);
        vec_t v;
        v.w = w; v.j = j; v.exp_cost = w*8 + j; v.exp_perm = p; v.exp_dup = d;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [$];
        int   skips [7];
        int   perm_before;

        // Tracker vectors against a table loaded with table[i]=i
        for (int w = 0; w < 8; w++) vecs.push_back(mk(w, w, (w == 7) ? 1 : 0, 0));
        skips = '{0, 1, 3, 4, 5, 6, 7};
        for (int k = 0; k < 7; k++) vecs.push_back(mk(skips[k], skips[k], 1, 0));
        for (int w = 0; w < 8; w++) vecs.push_back(mk(w, 7 - w, (w == 7) ? 2 : 1, 0));
        vecs.push_back(mk(0, 3, 2, 0));
        vecs.push_back(mk(0, 4, 2, 0));
        vecs.push_back(mk(1, 3, 2, 0));
        vecs.push_back(mk(2, 0, 2, 0));
        vecs.push_back(mk(3, 1, 2, 0));
        vecs.push_back(mk(4, 2, 2, 0));
        vecs.push_back(mk(5, 5, 2, 0));
        vecs.push_back(mk(6, 6, 2, 0));
        vecs.push_back(mk(7, 7, 3, 0));

        model_reset();
        do_reset();

        // Load table[i]=i; ready must rise exactly after the 64th write
        for (int i = 0; i < 64; i++) begin
            tick(1, i, 3, 5, 0, 0, 0);
            chk("load_ready", int'(ready), (i == 63) ? 1 : 0);
        end
        W = 3'd3; J = 3'd5; load_en = 1'b0;
        #1;
        chk("cost_w3_j5", int'(Cost), 29);

        foreach (vecs[i]) begin
            tick(0, 0, vecs[i].w, vecs[i].j, 0, 0, 0);
            chk("vec_cost", last_cost, vecs[i].exp_cost);
            chk("vec_perm", int'(perm_count), vecs[i].exp_perm);
            chk("vec_dup", int'(dup_err), int'(vecs[i].exp_dup));
        end

        // Repeated job inside a permutation; flag is sticky, counting continues
        tick(0, 0, 0, 2, 0, 0, 0);
        chk("dup_before", int'(dup_err), 0);
        tick(0, 0, 1, 2, 0, 0, 0);
        chk("dup_set", int'(dup_err), 1);
        chk("dup_perm_same", int'(perm_count), 3);
        for (int w = 0; w < 8; w++) tick(0, 0, w, w, 0, 0, 0);
        chk("dup_sticky", int'(dup_err), 1);
        chk("perm_after_dup", int'(perm_count), 4);

        // Result capture and freeze
        tick(0, 0, 0, 0, 1, 2, 'h1F3);
        chk("cap_done", int'(done), 1);
        chk("cap_min", int'(res_min_cost), 'h1F3);
        chk("cap_mc", int'(res_match_count), 2);
        for (int w = 0; w < 8; w++) tick(1, 99, w, w, 1, 7, 'h055);
        chk("frozen_perm", int'(perm_count), 4);
        chk("frozen_min", int'(res_min_cost), 'h1F3);
        chk("frozen_mc", int'(res_match_count), 2);

        // Reset mid-load, then full reload with random data (Valid ignored in LOAD)
        do_reset();
        for (int i = 0; i < 10; i++) tick(1, $urandom, i % 8, 0, 0, 0, 0);
        chk("partial_ready", int'(ready), 0);
        do_reset();
        for (int i = 0; i < 64; i++) begin
            if (i == 30) tick(0, $urandom, 1, 1, 0, 0, 0);
            tick(1, $urandom, $urandom_range(0, 7), $urandom_range(0, 7),
                 (i % 7) == 0, $urandom, $urandom);
            chk("reload_ready", int'(ready), (i == 63) ? 1 : 0);
        end
        chk("reload_done", int'(done), 0);

        for (int b = 0; b < 200; b++) burst();

        // Valid coinciding with the final W=7 access: both count and capture
        perm_before = int'(perm_count);
        for (int w = 0; w < 7; w++) tick(0, 0, w, 7 - w, 0, 0, 0);
        tick(0, 0, 7, 0, 1, 9, 'h2A5);
        chk("w7_valid_count", int'(perm_count), perm_before + 1);
        chk("w7_valid_done", int'(done), 1);
        chk("w7_valid_min", int'(res_min_cost), 'h2A5);
        chk("w7_valid_mc", int'(res_match_count), 9);
        for (int w = 0; w < 8; w++) tick(0, 0, w, w, 1, 1, 1);
        chk("w7_frozen_count", int'(perm_count), perm_before + 1);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
